// File: rtl/disp_wr_sched.sv
// Write-side sequencer for the time-capture and frequency-bin display RAMs.
// Define AUTO_TRIG_EN to force a capture after TRIG_TIMEOUT untriggered samples.
module disp_wr_sched #(
  parameter int TIME_DEPTH     = 640,
  parameter int DECIM          = 1,
  parameter int TRIG_LEVEL     = 0,
  parameter int HOLDOFF_FRAMES = 2,
  parameter int FREQ_BINS      = 80,
  parameter int MAG_SHIFT      = 6,
  parameter int MAG_MAX        = 230,
  parameter int TRIG_TIMEOUT   = 2048
) (
  input  logic        ck100MHz,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [7:0]  sample,
  input  logic        fft_valid,
  input  logic [9:0]  fft_index,
  input  logic [15:0] fft_mag,
  input  logic        frame_tick,
  input  logic        freeze,
  output logic        enaTime,
  output logic        weaTime,
  output logic [9:0]  addraTime,
  output logic [7:0]  dinaTime,
  output logic        weaFreq,
  output logic [9:0]  addraFreq,
  output logic [7:0]  dinaFreq,
  output logic        capture_busy,
  output logic        trig_seen
);

  typedef enum logic [1:0] {ARM, CAPTURE, HOLD} stateT;

  localparam logic signed [7:0] TRIG_L    = 8'(TRIG_LEVEL);
  localparam logic [9:0]        LAST_ADDR = 10'(TIME_DEPTH - 1);
  localparam logic [7:0]        DECIM_L   = 8'(DECIM);
  localparam logic [7:0]        HOLD_L    = 8'(HOLDOFF_FRAMES);

  stateT             state, stateNext;
  logic signed [7:0] prevSample;
  logic [9:0]        addrCnt;
  logic [7:0]        decimCnt;
  logic [7:0]        holdCnt;
  logic              realTrig, timeoutHit, startCapture, writeNow;
  logic [9:0]        writeAddr;
  logic [15:0]       magShifted;
  logic [7:0]        magSat;
  logic              fftWrite;

  assign realTrig = sample_valid && (prevSample < TRIG_L) && ($signed(sample) >= TRIG_L);

`ifdef AUTO_TRIG_EN
  localparam logic [15:0] TIMEOUT_L = 16'(TRIG_TIMEOUT);
  logic [15:0] timeoutCnt;

  assign timeoutHit = sample_valid && !realTrig && ((timeoutCnt + 16'd1) >= TIMEOUT_L);

  // Saturates one short of the limit so a frozen display forces on the next strobe.
  always_ff @(posedge ck100MHz) begin
    if (reset) begin
      timeoutCnt <= '0;
    end else if (state != ARM || realTrig || startCapture) begin
      timeoutCnt <= '0;
    end else if (sample_valid && !timeoutHit) begin
      timeoutCnt <= timeoutCnt + 16'd1;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_comb begin
    stateNext    = state;
    startCapture = 1'b0;
    writeNow     = 1'b0;
    writeAddr    = addrCnt;
    case (state)
      ARM: begin
        if (!freeze && (realTrig || timeoutHit)) begin
          startCapture = 1'b1;
          writeNow     = 1'b1;
          writeAddr    = '0;
          stateNext    = (LAST_ADDR == 10'd0) ? HOLD : CAPTURE;
        end
      end
      CAPTURE: begin
        if (sample_valid && decimCnt == DECIM_L) begin
          writeNow = 1'b1;
          if (addrCnt == LAST_ADDR) stateNext = HOLD;
        end
      end
      HOLD: begin
        if (holdCnt >= HOLD_L && !freeze) stateNext = ARM;
      end
      default: stateNext = ARM;
    endcase
  end

  assign magShifted = fft_mag >> MAG_SHIFT;
  assign magSat     = (magShifted > 16'(MAG_MAX)) ? 8'(MAG_MAX) : magShifted[7:0];
  assign fftWrite   = fft_valid && ({1'b0, fft_index} < 11'(FREQ_BINS)) && !freeze;

  // decimCnt holds the position of the incoming sample counted from the last
  // write, so a write returns it to 1 and the write lands on every DECIM-th sample.
  always_ff @(posedge ck100MHz) begin
    if (reset) begin
      state        <= ARM;
      prevSample   <= '0;
      addrCnt      <= '0;
      decimCnt     <= '0;
      holdCnt      <= '0;
      enaTime      <= 1'b0;
      weaTime      <= 1'b0;
      addraTime    <= '0;
      dinaTime     <= '0;
      weaFreq      <= 1'b0;
      addraFreq    <= '0;
      dinaFreq     <= '0;
      capture_busy <= 1'b0;
      trig_seen    <= 1'b0;
    end else begin
      state        <= stateNext;
      capture_busy <= (stateNext == CAPTURE);
      if (sample_valid) prevSample <= sample;

      enaTime <= writeNow;
      weaTime <= writeNow;
      if (writeNow) begin
        addraTime <= writeAddr;
        dinaTime  <= sample;
      end

      if (startCapture) begin
        trig_seen <= realTrig;
        addrCnt   <= (LAST_ADDR == 10'd0) ? 10'd0 : 10'd1;
        decimCnt  <= 8'd1;
      end else if (state == CAPTURE && sample_valid) begin
        if (writeNow) begin
          decimCnt <= 8'd1;
          addrCnt  <= (addrCnt == LAST_ADDR) ? 10'd0 : addrCnt + 10'd1;
        end else begin
          decimCnt <= decimCnt + 8'd1;
        end
      end

      // Only ticks seen while already in HOLD count toward the holdoff.
      if (state != HOLD) begin
        holdCnt <= '0;
      end else if (frame_tick && holdCnt < HOLD_L) begin
        holdCnt <= holdCnt + 8'd1;
      end

      weaFreq <= fftWrite;
      if (fftWrite) begin
        addraFreq <= fft_index;
        dinaFreq  <= magSat;
      end
    end
  end

endmodule

// File: tb/tb_disp_wr_sched.sv
// Scoreboard bench for disp_wr_sched: DECIM=1 and DECIM=4 instances share stimulus
// apart from their sample strobes; expected writes are queued when driven.
module tb_disp_wr_sched;

  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic [7:0] data;
  } expT;

  logic        ck100MHz = 1'b0;
  logic        reset;
  logic        svA, svB;
  logic [7:0]  sample;
  logic        fft_valid;
  logic [9:0]  fft_index;
  logic [15:0] fft_mag;
  logic        frame_tick;
  logic        freeze;

  logic        enaA, weaA, wfA, busyA, trigA;
  logic [9:0]  addrA, afA;
  logic [7:0]  dinA, dfA;
  logic        enaB, weaB, wfB, busyB, trigB;
  logic [9:0]  addrB, afB;
  logic [7:0]  dinB, dfB;

  int  cyc = 0;
  int  testsRun = 0;
  int  failCount = 0;
  int  wrCntA = 0, wrCntB = 0, wrCntF = 0;
  expT qA[$], qB[$], qF[$];
  expT eA, eB, eF;

  disp_wr_sched #(.DECIM(1), .TRIG_TIMEOUT(16)) dutA (
    .ck100MHz(ck100MHz), .reset(reset), .sample_valid(svA), .sample(sample),
    .fft_valid(fft_valid), .fft_index(fft_index), .fft_mag(fft_mag),
    .frame_tick(frame_tick), .freeze(freeze),
    .enaTime(enaA), .weaTime(weaA), .addraTime(addrA), .dinaTime(dinA),
    .weaFreq(wfA), .addraFreq(afA), .dinaFreq(dfA),
    .capture_busy(busyA), .trig_seen(trigA));

  disp_wr_sched #(.DECIM(4)) dutB (
    .ck100MHz(ck100MHz), .reset(reset), .sample_valid(svB), .sample(sample),
    .fft_valid(1'b0), .fft_index(fft_index), .fft_mag(fft_mag),
    .frame_tick(frame_tick), .freeze(freeze),
    .enaTime(enaB), .weaTime(weaB), .addraTime(addrB), .dinaTime(dinB),
    .weaFreq(wfB), .addraFreq(afB), .dinaFreq(dfB),
    .capture_busy(busyB), .trig_seen(trigB));

  always #5 ck100MHz = ~ck100MHz;

  always @(posedge ck100MHz) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ck100MHz);
      #1;
      svA = 1'b0; svB = 1'b0; fft_valid = 1'b0; frame_tick = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit toB, input logic [7:0] s, input bit expWr, input int addr);
    expT e;
    sample = s;
    if (toB) svB = 1'b1; else svA = 1'b1;
    if (expWr) begin
      e.cyc = cyc + 1; e.addr = 10'(addr); e.data = s;
      if (toB) qB.push_back(e); else qA.push_back(e);
    end
    step(1);
  endtask

  task automatic queueFft(input int idx, input logic [15:0] mag, input bit expWr, input logic [7:0] din);
    expT e;
    fft_valid = 1'b1; fft_index = 10'(idx); fft_mag = mag;
    if (expWr) begin
      e.cyc = cyc + 1; e.addr = 10'(idx); e.data = din;
      qF.push_back(e);
    end
  endtask

  task automatic sendFft(input int idx, input logic [15:0] mag, input bit expWr, input logic [7:0] din);
    queueFft(idx, mag, expWr, din);
    step(1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ena"},  32'(enaA),  0);
    checkOutput({tag, "_wea"},  32'(weaA),  0);
    checkOutput({tag, "_addr"}, 32'(addrA), 0);
    checkOutput({tag, "_din"},  32'(dinA),  0);
    checkOutput({tag, "_wf"},   32'(wfA),   0);
    checkOutput({tag, "_af"},   32'(afA),   0);
    checkOutput({tag, "_df"},   32'(dfA),   0);
    checkOutput({tag, "_busy"}, 32'(busyA), 0);
    checkOutput({tag, "_trig"}, 32'(trigA), 0);
  endtask

  always @(negedge ck100MHz) begin
    if (weaA || enaA) checkOutput("enaEqWeaA", 32'(enaA), 32'(weaA));
    if (weaA) begin
      wrCntA++;
      if (qA.size() == 0) checkOutput("unexpectedWrA", 32'(weaA), 0);
      else begin
        eA = qA.pop_front();
        checkOutput("cycA",  cyc,          eA.cyc);
        checkOutput("addrA", 32'(addrA), 32'(eA.addr));
        checkOutput("dinA",  32'(dinA),  32'(eA.data));
      end
    end
  end

  always @(negedge ck100MHz) begin
    if (wfB) checkOutput("unexpectedWfB", 32'(wfB), 0);
    if (weaB) begin
      wrCntB++;
      if (qB.size() == 0) checkOutput("unexpectedWrB", 32'(weaB), 0);
      else begin
        eB = qB.pop_front();
        checkOutput("cycB",  cyc,          eB.cyc);
        checkOutput("addrB", 32'(addrB), 32'(eB.addr));
        checkOutput("dinB",  32'(dinB),  32'(eB.data));
      end
    end
  end

  always @(negedge ck100MHz) begin
    if (wfA) begin
      wrCntF++;
      if (qF.size() == 0) checkOutput("unexpectedWf", 32'(wfA), 0);
      else begin
        eF = qF.pop_front();
        checkOutput("cycF",  cyc,        eF.cyc);
        checkOutput("addrF", 32'(afA), 32'(eF.addr));
        checkOutput("dinF",  32'(dfA), 32'(eF.data));
      end
    end
  end

  initial begin
    reset = 1'b1; svA = 1'b0; svB = 1'b0; sample = '0;
    fft_valid = 1'b0; fft_index = '0; fft_mag = '0; frame_tick = 1'b0; freeze = 1'b0;
    step(3);
    checkAllZero("reset");
    reset = 1'b0;
    step(1);

    // DECIM=1 ramp capture, with one FFT bin landing in the same cycle as a sample
    applyStimulus(0, 8'hFB, 0, 0);
    applyStimulus(0, 8'hFF, 0, 0);
    for (int i = 0; i < 640; i++) begin
      if (i == 100) queueFft(5, 16'h1000, 1, 8'd64);
      applyStimulus(0, 8'(3 + 4 * i), 1, i);
      if (i == 0) begin
        checkOutput("firstWea",  32'(weaA),  1);
        checkOutput("firstAddr", 32'(addrA), 0);
        checkOutput("firstDin",  32'(dinA),  32'h03);
      end
      if (i == 320) checkOutput("busyMid", 32'(busyA), 1);
    end
    step(1);
    checkOutput("busyAfterCap", 32'(busyA), 0);
    checkOutput("trigSeenCap",  32'(trigA), 1);
    checkOutput("qAEmptyCap",   qA.size(), 0);
    checkOutput("wrCntCap",     wrCntA,    640);

    // Holdoff: one tick is not enough, the second re-arms
    step(2);
    frame_tick = 1'b1; step(1);
    step(2);
    applyStimulus(0, 8'hFF, 0, 0);
    applyStimulus(0, 8'h03, 0, 0);
    step(2);
    checkOutput("busyAfterTick1", 32'(busyA), 0);
    frame_tick = 1'b1; step(1);
    step(2);
    applyStimulus(0, 8'hFF, 0, 0);
    for (int i = 0; i < 300; i++) applyStimulus(0, 8'(3 + 4 * i), 1, i);

    // Reset while the address counter sits at 300
    reset = 1'b1;
    step(1);
    checkAllZero("rstMid");
    reset = 1'b0;
    applyStimulus(0, 8'hFF, 0, 0);
    for (int i = 0; i < 640; i++) applyStimulus(0, 8'(3 + 4 * i), 1, i);
    step(1);
    checkOutput("busyAfterCap2", 32'(busyA), 0);
    checkOutput("wrCntCap2",     wrCntA,    640 + 300 + 640);

    // Freeze held over the second tick keeps the display in HOLD
    frame_tick = 1'b1; step(1);
    step(1);
    freeze = 1'b1;
    frame_tick = 1'b1; step(1);
    step(3);
    applyStimulus(0, 8'hFF, 0, 0);
    applyStimulus(0, 8'h03, 0, 0);
    step(2);
    checkOutput("busyFrozen", 32'(busyA), 0);
    freeze = 1'b0;
    step(2);
    applyStimulus(0, 8'hFF, 0, 0);
    applyStimulus(0, 8'h03, 1, 0);
    checkOutput("busyUnfrozen", 32'(busyA), 1);
    checkOutput("trigUnfrozen", 32'(trigA), 1);

    // Frequency path, back-to-back strobes
    sendFft(5,    16'h1000, 1, 8'd64);
    sendFft(6,    16'hFFFF, 1, 8'd230);
    sendFft(80,   16'h1000, 0, 8'd0);
    sendFft(79,   16'd14720, 1, 8'd230);
    sendFft(2,    16'd14784, 1, 8'd230);
    sendFft(1,    16'd14719, 1, 8'd229);
    freeze = 1'b1;
    sendFft(3,    16'h0400, 0, 8'd0);
    freeze = 1'b0;
    sendFft(1023, 16'hFFFF, 0, 8'd0);
    sendFft(0,    16'h003F, 1, 8'd0);
    step(2);
    checkOutput("qFEmpty",  qF.size(), 0);
    checkOutput("wrCntF",   wrCntF,    7);

    // DECIM=4 capture on the second instance
    applyStimulus(1, 8'hFB, 0, 0);
    applyStimulus(1, 8'hFF, 0, 0);
    applyStimulus(1, 8'h03, 1, 0);
    for (int k = 1; k <= 639 * 4; k++) applyStimulus(1, 8'(3 + 4 * k), (k % 4) == 0, k / 4);
    step(2);
    checkOutput("busyB",   32'(busyB), 0);
    checkOutput("trigB",   32'(trigB), 1);
    checkOutput("qBEmpty", qB.size(),  0);
    checkOutput("wrCntB",  wrCntB,     640);

    // Silent DC input: forced trigger only when AUTO_TRIG_EN is built in
    reset = 1'b1; step(1); reset = 1'b0;
    for (int i = 0; i < 15; i++) applyStimulus(0, 8'h10, 0, 0);
    checkOutput("busyBeforeTimeout", 32'(busyA), 0);
`ifdef AUTO_TRIG_EN
    applyStimulus(0, 8'h10, 1, 0);
    checkOutput("timeoutBusy", 32'(busyA), 1);
    checkOutput("timeoutTrig", 32'(trigA), 0);
`else
    applyStimulus(0, 8'h10, 0, 0);
    checkOutput("noTimeoutBusy", 32'(busyA), 0);
    checkOutput("noTimeoutTrig", 32'(trigA), 0);
`endif
    step(2);
    checkOutput("qAEmptyEnd", qA.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
